text_glyph_pipe: RTL and testbench
==================================

# text_glyph_pipe

Pipelined, parametrised text-mode pixel generator for the VGA path. Each cycle it takes a pixel coordinate and maps it to a character cell. It fetches the packed character word from video RAM and selects the character byte. It then fetches the glyph row from the font ROM and emits one pixel bit, with inverse-video and a blinking cursor. It sits between the VGA controller (drawX/drawY) and the colour mapper, driving two synchronous-read memories.

## Interface
Parameters:
- COLS, 80, character columns per row
- ROWS, 30, character rows
- CELL_W_LOG2, 3, log2 cell width in pixels (8); font row width = 1<<CELL_W_LOG2
- CELL_H_LOG2, 4, log2 cell height (16)
- CPW_LOG2, 2, log2 characters packed per VRAM word (4, byte 0 = lowest address)
- VRAM_AW, 10, VRAM word address width
- BLINK_FRAMES, 32, frames per cursor blink half-period

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-low reset
- pix_valid_in  in  1  drawX/drawY valid this cycle
- drawX, drawY  in  10 each  pixel coordinate
- frame_start  in  1  one-cycle pulse per frame
- cursor_en  in  1  cursor display enable
- cursor_col  in  7  cursor cell column
- cursor_row  in  5  cursor cell row
- vram_addr  out  VRAM_AW  registered VRAM word address
- vram_data  in  8<<CPW_LOG2  VRAM read data, valid the cycle after vram_addr
- font_addr  out  7+CELL_H_LOG2  registered font ROM address {code[6:0], glyph row}
- font_data  in  1<<CELL_W_LOG2  glyph row, MSB = leftmost pixel, valid the cycle after font_addr
- draw_code  out  8  character code of the output pixel
- pixel_on  out  1  foreground pixel
- pix_valid_out  out  1  pixel_on/draw_code valid

## Operation
- Cell math at input: col = drawX>>CELL_W_LOG2, row = drawY>>CELL_H_LOG2, fx = drawX low CELL_W_LOG2 bits, fy = drawY low CELL_H_LOG2 bits.
- Linear index: lin = col + row*COLS, 12 bits. Constant multiply only; no divide or modulo.
- vram_addr = lin>>CPW_LOG2, truncated to VRAM_AW. lane = lin low CPW_LOG2 bits.
- blank = (col >= COLS) or (row >= ROWS). When blank, vram_addr is still driven, but the output is forced to pixel_on=0 and draw_code=0x00.
- cursor_hit = cursor_en & (col==cursor_col) & (row==cursor_row) & blink_state. It is sampled at stage 1.
- code = vram_data byte[lane]. font_addr = {code[6:0], fy}. code[7] = inverse flag.
- pixel_on = font_data[(1<<CELL_W_LOG2)-1-fx] ^ code[7] ^ cursor_hit, gated by !blank.
- Blink: frame counter counts frame_start pulses 0..BLINK_FRAMES-1. On the pulse at BLINK_FRAMES-1 the counter wraps to 0 and blink_state toggles.
- No stall or back-pressure. A new pixel can be accepted every cycle. pix_valid_in=0 inserts a bubble that propagates as pix_valid_out=0.
- While pix_valid_out=0, pixel_on=0 and draw_code=0.

## Timing
- Input sampled at edge E1 (end of cycle k).
  - E1: vram_addr, lane, fx, fy, blank, cursor_hit and valid are registered.
  - E2: metadata delayed; vram_data is valid during cycle k+2.
  - E3: font_addr, draw_code candidate and inverse flag are registered.
  - E4: metadata delayed; font_data is valid during cycle k+4.
  - E5: pixel_on, draw_code and pix_valid_out are registered.
- Latency is 5 cycles. Throughput is 1 pixel/cycle, and output order equals input order.
- frame_start in the same cycle as a pixel: that pixel uses the pre-toggle blink_state.
- Reset asserted (low), including mid-stream:
  - All pipeline valid bits are cleared immediately and in-flight pixels are discarded.
  - vram_addr=0, font_addr=0, draw_code=0, pixel_on=0, pix_valid_out=0.
  - Frame counter = 0, blink_state = 1 (cursor visible).
- After reset is released, the first valid output appears 5 cycles after the first accepted input.

## Test plan
- Reset: drive Reset low mid-stream with 3 pixels in flight → all outputs 0 immediately; no pix_valid_out pulse after release until 5 cycles past the next valid input.
- Origin pixel: drawX=0, drawY=0; vram_data=0x00000041; font_data=0x80 → vram_addr=0 at E1, font_addr=0x410 at E3, pixel_on=1 and draw_code=0x41 at E5.
- Lane/row select: drawX=24, drawY=18 → lin=83, vram_addr=20, lane 3. vram_data=0x41000000 → font_addr=0x412. With font_data=0x10 and fx=0, pixel_on=0; with drawX=27, pixel_on=1.
- Inverse: code 0xC1, font_data=0x00, fx=0 → font_addr=0x410, pixel_on=1, draw_code=0xC1.
- Cursor blink: cursor_en=1, col=3, row=1, pixel drawX=24, drawY=16, font_data=0x00 → pixel_on=1. Then apply 32 frame_start pulses → same pixel gives pixel_on=0; after 32 more pulses it returns to 1.
- Stream/blank: back-to-back valid pixels drawX=632..641 on drawY=0 with one bubble → outputs in order with matching bubble. drawX≥640 gives pixel_on=0, draw_code=0.

Source files
------------

// File: rtl/text_glyph_pipe.sv
// Five-stage text-mode pixel generator: cell math -> VRAM fetch -> byte/lane select ->
// font ROM fetch -> glyph bit with inverse video and blinking cursor.
module text_glyph_pipe #(
   parameter int COLS         = 80,
   parameter int ROWS         = 30,
   parameter int CELL_W_LOG2  = 3,
   parameter int CELL_H_LOG2  = 4,
   parameter int CPW_LOG2     = 2,
   parameter int VRAM_AW      = 10,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          pix_valid_in,
   input  logic [9:0]                    drawX,
   input  logic [9:0]                    drawY,
   input  logic                          frame_start,
   input  logic                          cursor_en,
   input  logic [6:0]                    cursor_col,
   input  logic [4:0]                    cursor_row,
   output logic [VRAM_AW-1:0]            vram_addr,
   input  logic [(8<<CPW_LOG2)-1:0]      vram_data,
   output logic [7+CELL_H_LOG2-1:0]      font_addr,
   input  logic [(1<<CELL_W_LOG2)-1:0]   font_data,
   output logic [7:0]                    draw_code,
   output logic                          pixel_on,
   output logic                          pix_valid_out
);

   localparam int COL_W = 10 - CELL_W_LOG2;
   localparam int ROW_W = 10 - CELL_H_LOG2;
   localparam int LIN_W = 12;
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [COL_W-1:0]       w_col;
   logic [ROW_W-1:0]       w_row;
   logic [LIN_W-1:0]       w_lin;
   logic                   w_blank;
   logic                   w_hit;
   logic [7:0]             w_code;
   logic [CELL_W_LOG2-1:0] w_fx_idx;
   logic                   w_fbit;
   logic                   w_show;

   logic [FC_W-1:0]        r_frame_cnt;
   logic                   r_blink;

   logic                   r1_valid, r2_valid, r3_valid, r4_valid;
   logic [CPW_LOG2-1:0]    r1_lane, r2_lane;
   logic [CELL_W_LOG2-1:0] r1_fx, r2_fx, r3_fx, r4_fx;
   logic [CELL_H_LOG2-1:0] r1_fy, r2_fy;
   logic                   r1_blank, r2_blank, r3_blank, r4_blank;
   logic                   r1_hit, r2_hit, r3_hit, r4_hit;
   logic [7:0]             r3_code, r4_code;

   assign w_col   = drawX[9:CELL_W_LOG2];
   assign w_row   = drawY[9:CELL_H_LOG2];
   assign w_lin   = LIN_W'(w_col) + LIN_W'(w_row) * LIN_W'(COLS);
   assign w_blank = (32'(w_col) >= COLS) || (32'(w_row) >= ROWS);
   assign w_hit   = cursor_en && (32'(w_col) == 32'(cursor_col))
                    && (32'(w_row) == 32'(cursor_row)) && r_blink;

   // Byte 0 of the packed word is the lowest character address.
   assign w_code   = vram_data[{r2_lane, 3'b000} +: 8];
   // Cell width is a power of two, so (width-1-fx) is just ~fx.
   assign w_fx_idx = ~r4_fx;
   assign w_fbit   = font_data[w_fx_idx];
   assign w_show   = r4_valid && !r4_blank;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_frame_cnt <= '0;
         r_blink     <= 1'b1;
      end else if (frame_start) begin
         if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
            r_frame_cnt <= '0;
            r_blink     <= ~r_blink;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r1_valid  <= 1'b0;
         vram_addr <= '0;
         r1_lane   <= '0;
         r1_fx     <= '0;
         r1_fy     <= '0;
         r1_blank  <= 1'b0;
         r1_hit    <= 1'b0;
         r2_valid  <= 1'b0;
         r2_lane   <= '0;
         r2_fx     <= '0;
         r2_fy     <= '0;
         r2_blank  <= 1'b0;
         r2_hit    <= 1'b0;
      end else begin
         r1_valid  <= pix_valid_in;
         vram_addr <= VRAM_AW'(w_lin >> CPW_LOG2);
         r1_lane   <= w_lin[CPW_LOG2-1:0];
         r1_fx     <= drawX[CELL_W_LOG2-1:0];
         r1_fy     <= drawY[CELL_H_LOG2-1:0];
         r1_blank  <= w_blank;
         r1_hit    <= w_hit;
         r2_valid  <= r1_valid;
         r2_lane   <= r1_lane;
         r2_fx     <= r1_fx;
         r2_fy     <= r1_fy;
         r2_blank  <= r1_blank;
         r2_hit    <= r1_hit;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r3_valid  <= 1'b0;
         font_addr <= '0;
         r3_code   <= '0;
         r3_fx     <= '0;
         r3_blank  <= 1'b0;
         r3_hit    <= 1'b0;
         r4_valid  <= 1'b0;
         r4_code   <= '0;
         r4_fx     <= '0;
         r4_blank  <= 1'b0;
         r4_hit    <= 1'b0;
      end else begin
         r3_valid  <= r2_valid;
         font_addr <= {w_code[6:0], r2_fy};
         r3_code   <= w_code;
         r3_fx     <= r2_fx;
         r3_blank  <= r2_blank;
         r3_hit    <= r2_hit;
         r4_valid  <= r3_valid;
         r4_code   <= r3_code;
         r4_fx     <= r3_fx;
         r4_blank  <= r3_blank;
         r4_hit    <= r3_hit;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pix_valid_out <= 1'b0;
         pixel_on      <= 1'b0;
         draw_code     <= 8'h00;
      end else begin
         pix_valid_out <= r4_valid;
         pixel_on      <= w_show && (w_fbit ^ r4_code[7] ^ r4_hit);
         draw_code     <= w_show ? r4_code : 8'h00;
      end
   end

endmodule

// File: tb/tb_text_glyph_pipe.sv
// Directed bench for text_glyph_pipe; behavioural VRAM/font ROM answer one cycle after each address.
module tb_text_glyph_pipe;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        pix_valid_in = 1'b0;
   logic [9:0]  drawX = '0;
   logic [9:0]  drawY = '0;
   logic        frame_start = 1'b0;
   logic        cursor_en = 1'b0;
   logic [6:0]  cursor_col = '0;
   logic [4:0]  cursor_row = '0;
   logic [9:0]  vram_addr;
   logic [31:0] vram_data = '0;
   logic [10:0] font_addr;
   logic [7:0]  font_data = '0;
   logic [7:0]  draw_code;
   logic        pixel_on;
   logic        pix_valid_out;

   int errors = 0;
   int checks = 0;

   logic [31:0] vram [0:1023];
   logic [7:0]  font [0:2047];
   logic [9:0]  exp_q [$];

   always #5 Clk = ~Clk;

   text_glyph_pipe dut (
      .Clk(Clk), .Reset(Reset), .pix_valid_in(pix_valid_in),
      .drawX(drawX), .drawY(drawY), .frame_start(frame_start),
      .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
      .vram_addr(vram_addr), .vram_data(vram_data),
      .font_addr(font_addr), .font_data(font_data),
      .draw_code(draw_code), .pixel_on(pixel_on), .pix_valid_out(pix_valid_out)
   );

   always @(posedge Clk) begin
      vram_data <= vram[vram_addr];
      font_data <= font[font_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".vaddr"}, 32'(vram_addr), 32'h0);
      chk({tag, ".faddr"}, 32'(font_addr), 32'h0);
      chk({tag, ".code"},  32'(draw_code), 32'h0);
      chk({tag, ".on"},    32'(pixel_on), 32'h0);
      chk({tag, ".vout"},  32'(pix_valid_out), 32'h0);
   endtask

   // Called at a falling edge; drives one pixel and follows it to the output.
   task automatic run_pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic fs, input logic [9:0] ev, input logic [10:0] ef,
                            input logic eon, input logic [7:0] ecode);
      drawX = x; drawY = y; pix_valid_in = 1'b1; frame_start = fs;
      @(negedge Clk);
      chk({tag, ".vaddr"}, 32'(vram_addr), 32'(ev));
      pix_valid_in = 1'b0; frame_start = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      chk({tag, ".faddr"}, 32'(font_addr), 32'(ef));
      @(negedge Clk);
      chk({tag, ".early"}, 32'(pix_valid_out), 32'h0);
      @(negedge Clk);
      chk({tag, ".vout"}, 32'(pix_valid_out), 32'h1);
      chk({tag, ".on"},   32'(pixel_on), 32'(eon));
      chk({tag, ".code"}, 32'(draw_code), 32'(ecode));
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         frame_start = 1'b1;
         @(negedge Clk);
         frame_start = 1'b0;
         @(negedge Clk);
      end
   endtask

   initial begin
      logic [9:0] sx [0:10];
      logic [9:0] sexp [0:10];
      logic [9:0] got;
      int k;

      for (int i = 0; i < 1024; i++) vram[i] = 32'h0;
      for (int i = 0; i < 2048; i++) font[i] = 8'h0;

      // Reset state
      repeat (2) @(negedge Clk);
      chk_all_zero("reset0");
      Reset = 1'b1;
      @(negedge Clk);

      // Origin pixel
      vram[0] = 32'h0000_0041;
      font[11'h410] = 8'h80;
      run_pixel("origin", 10'd0, 10'd0, 1'b0, 10'd0, 11'h410, 1'b1, 8'h41);

      // Lane 3, glyph row 2
      vram[20] = 32'h4100_0000;
      font[11'h412] = 8'h10;
      run_pixel("lane_fx0", 10'd24, 10'd18, 1'b0, 10'd20, 11'h412, 1'b0, 8'h41);
      run_pixel("lane_fx3", 10'd27, 10'd18, 1'b0, 10'd20, 11'h412, 1'b1, 8'h41);

      // Inverse video
      vram[0] = 32'h0000_00C1;
      font[11'h410] = 8'h00;
      run_pixel("inverse", 10'd0, 10'd0, 1'b0, 10'd0, 11'h410, 1'b1, 8'hC1);

      // Cursor blink
      cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 5'd1;
      run_pixel("cur_on", 10'd24, 10'd16, 1'b0, 10'd20, 11'h410, 1'b1, 8'h41);
      pulses(32);
      run_pixel("cur_off", 10'd24, 10'd16, 1'b0, 10'd20, 11'h410, 1'b0, 8'h41);
      pulses(31);
      run_pixel("cur_off31", 10'd24, 10'd16, 1'b0, 10'd20, 11'h410, 1'b0, 8'h41);
      pulses(1);
      run_pixel("cur_back", 10'd24, 10'd16, 1'b0, 10'd20, 11'h410, 1'b1, 8'h41);
      pulses(31);
      run_pixel("cur_fs_pre", 10'd24, 10'd16, 1'b1, 10'd20, 11'h410, 1'b1, 8'h41);
      run_pixel("cur_fs_post", 10'd24, 10'd16, 1'b0, 10'd20, 11'h410, 1'b0, 8'h41);

      // Mid-stream reset: blink is currently off, reset must turn it back on
      cursor_en = 1'b0;
      drawX = 10'd27; drawY = 10'd18; pix_valid_in = 1'b1;
      repeat (6) @(negedge Clk);
      chk("prerst.vout", 32'(pix_valid_out), 32'h1);
      chk("prerst.on",   32'(pixel_on), 32'h1);
      #2 Reset = 1'b0;
      #1 chk_all_zero("midrst");
      pix_valid_in = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         chk("postrst.idle", 32'(pix_valid_out), 32'h0);
      end
      cursor_en = 1'b1;
      run_pixel("postrst_cur", 10'd24, 10'd16, 1'b0, 10'd20, 11'h410, 1'b1, 8'h41);
      cursor_en = 1'b0;

      // Stream across the right edge with one bubble; expected word = {valid, on, code}
      vram[19] = 32'hA500_0000;
      font[11'h250] = 8'b1100_1010;
      sx   = '{10'd632, 10'd633, 10'd634, 10'd635, 10'd0, 10'd636,
             10'd637, 10'd638, 10'd639, 10'd640, 10'd641};
      sexp = '{{2'b10, 8'hA5}, {2'b10, 8'hA5}, {2'b11, 8'hA5}, {2'b11, 8'hA5},
             {2'b00, 8'h00}, {2'b10, 8'hA5}, {2'b11, 8'hA5}, {2'b10, 8'hA5},
             {2'b11, 8'hA5}, {2'b10, 8'h00}, {2'b10, 8'h00}};
      drawY = 10'd0;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (i >= 5) begin
            got = {pix_valid_out, pixel_on, draw_code};
            chk($sformatf("stream%0d", k), 32'(got), 32'(exp_q.pop_front()));
            k++;
         end
         if (i < 11) begin
            drawX = sx[i];
            pix_valid_in = (i != 4);
            exp_q.push_back(sexp[i]);
         end else begin
            pix_valid_in = 1'b0;
         end
         @(negedge Clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
